// File: rtl/dmem_responder.sv
// Byte-enabled word RAM target with valid/ready request and response channels and wait-state emulation.
// Define DMEM_RANGE_CHECK_EN to flag addresses outside the BASE_ADDR window as errors.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
`ifdef DMEM_RANGE_CHECK_EN
   localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   typedef struct packed {
      logic          we;
      logic          err;
      logic [AW-1:0] idx;
      logic [31:0]   wdata;
      logic [3:0]    be;
   } req_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   req_t        req_q;
   req_t        req_c;
   req_t        acc_c;
   logic [31:0] rd_q;
   logic [31:0] ram [DEPTH_WORDS];
   logic [31:0] offset_c;
   logic        accept_c;
   logic        enter_resp_c;
   logic        unused_c;

   assign req_ready = (state == ST_IDLE);
   assign accept_c  = req_valid && req_ready;
   assign offset_c  = req_addr - BASE_ADDR;
   assign unused_c  = ^{offset_c, req_addr};

   // Decode the live request into the form held for the rest of the transaction
   always_comb begin
      req_c.we    = req_we;
      req_c.wdata = req_wdata;
      req_c.be    = req_be;
`ifdef DMEM_RANGE_CHECK_EN
      req_c.idx   = offset_c[AW+1:2];
      req_c.err   = (req_be == 4'b0000) || (offset_c >= WIN_BYTES);
`else
      req_c.idx   = req_addr[AW+1:2];
      req_c.err   = (req_be == 4'b0000);
`endif
   end

   // With zero wait states the RAM is accessed on the accept edge, before req_q is loaded
   assign acc_c        = (state == ST_IDLE) ? req_c : req_q;
   assign enter_resp_c = (state == ST_IDLE) ? (accept_c && (WAIT_CYCLES == 0))
                                            : ((state == ST_WAIT) && (wait_cnt == WAIT_LAST));

   always_ff @(posedge clk) begin
      if (enter_resp_c && !acc_c.err) begin
         if (acc_c.we) begin
            for (int i = 0; i < 4; i++) begin
               if (acc_c.be[i]) ram[acc_c.idx][8*i +: 8] <= acc_c.wdata[8*i +: 8];
            end
         end else begin
            rd_q <= ram[acc_c.idx];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         wait_cnt  <= 4'd0;
         req_q     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept_c) begin
                  req_q    <= req_c;
                  wait_cnt <= 4'd0;
                  state    <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == WAIT_LAST) state <= ST_RESP;
               else                       wait_cnt <= wait_cnt + 4'd1;
            end
            ST_RESP: begin
               // Response is presented one cycle after the RAM access, then held until taken
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= req_q.err;
                  rsp_rdata <= (req_q.err || req_q.we) ? 32'd0 : rd_q;
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= 32'd0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
